// File: rtl/stream_demux_1xn_if.sv
// Handshake bundle for stream_demux_1xn: one upstream stream in, NUM_CH
// downstream streams out, all using valid/ready flow control.
interface stream_demux_1xn_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  // Handshake: a beat moves when valid && ready on the same rising edge;
  // valid never waits on ready, and a raised valid holds its payload stable
  // until that transfer happens.
  logic [DATA_W-1:0]        s_data;
  logic                     s_valid;
  logic                     s_last;
  logic [SEL_W-1:0]         s_sel;
  logic                     s_ready;
  logic [NUM_CH*DATA_W-1:0] m_data;
  logic [NUM_CH-1:0]        m_valid;
  logic [NUM_CH-1:0]        m_last;
  logic [NUM_CH-1:0]        m_ready;

  modport slave (
    input  s_data, s_valid, s_last, s_sel, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, s_last, s_sel, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N packet demultiplexer: the select on a packet's first beat
// picks the channel for the whole packet; out-of-range selects drop the packet.
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_demux_1xn_if.slave   bus,
  output logic                busy,
  output logic                drop_pulse,
  output logic [7:0]          drop_cnt,
  output logic [1:0]          dbg_state
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  // One extra bit so NUM_CH itself is representable (e.g. 256 with SEL_W 8).
  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W+1)'(NUM_CH);

  logic [1:0]        state;
  logic [SEL_W-1:0]  cur_sel;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] lst;
  logic [DATA_W-1:0] dat [NUM_CH];

  logic              sel_ok;
  logic              drop_now;
  logic              tgt_free;
  logic              acc;
  logic [SEL_W-1:0]  tgt;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  always_comb begin
    sel_ok   = ({1'b0, bus.s_sel} < NUM_CH_V);
    tgt      = (state == ROUTE) ? cur_sel : bus.s_sel;
    drop_now = (state == DROP) || ((state == IDLE) && !sel_ok);
    tgt_free = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = !full[k] || bus.m_ready[k];
    end
    bus.s_ready = rst_n && (drop_now || tgt_free);
    acc         = bus.s_valid && bus.s_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      push[k] = acc && !drop_now && (tgt == SEL_W'(k));
      pop[k]  = full[k] && bus.m_ready[k];
    end
  end

  // Empty channels present zeros so stale payloads never leak out.
  always_comb begin
    bus.m_data  = '0;
    bus.m_valid = full;
    bus.m_last  = full & lst;
    for (int k = 0; k < NUM_CH; k++) begin
      if (full[k]) bus.m_data[k*DATA_W +: DATA_W] = dat[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_sel    <= '0;
      full       <= '0;
      lst        <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
      for (int k = 0; k < NUM_CH; k++) dat[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) begin
          full[k] <= 1'b1;
          dat[k]  <= bus.s_data;
          lst[k]  <= bus.s_last;
        end else if (pop[k]) begin
          full[k] <= 1'b0;
        end
      end
      drop_pulse <= acc && drop_now;
      if (acc && drop_now && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (acc) begin
            if (sel_ok) begin
              cur_sel <= bus.s_sel;
              if (!bus.s_last) state <= ROUTE;
            end else if (!bus.s_last) begin
              state <= DROP;
            end
          end
        end
        ROUTE, DROP: if (acc && bus.s_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed bench for stream_demux_1xn: an 8-channel instance for routing and
// backpressure, a 5-channel instance for out-of-range drops.
module tb_stream_demux_1xn;
  logic clk = 1'b0;
  logic rst_n;

  stream_demux_1xn_if #(.DATA_W(8), .NUM_CH(8)) if8 ();
  stream_demux_1xn_if #(.DATA_W(8), .NUM_CH(5)) if5 ();

  logic       busy8, drop_pulse8, busy5, drop_pulse5;
  logic [7:0] drop_cnt8, drop_cnt5;
  logic [1:0] dbg8, dbg5;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8),
    .busy(busy8), .drop_pulse(drop_pulse8), .drop_cnt(drop_cnt8), .dbg_state(dbg8)
  );

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5),
    .busy(busy5), .drop_pulse(drop_pulse5), .drop_cnt(drop_cnt5), .dbg_state(dbg5)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive8(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
    if8.s_valid = v; if8.s_sel = sel; if8.s_data = d; if8.s_last = l;
  endtask

  task automatic drive5(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
    if5.s_valid = v; if5.s_sel = sel; if5.s_data = d; if5.s_last = l;
  endtask

  initial begin
    int pulses;
    logic [7:0] e;
    rst_n = 1'b1;
    drive8(1'b0, 3'd0, 8'h00, 1'b0);
    drive5(1'b0, 3'd0, 8'h00, 1'b0);
    if8.m_ready = 8'hFF;
    if5.m_ready = 5'h1F;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", if8.m_valid, 0);
    chk("rst_m_data", if8.m_data, 0);
    chk("rst_m_last", if8.m_last, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_drop_pulse", drop_pulse5, 0);
    chk("rst_drop_cnt", drop_cnt5, 0);
    chk("rst_s_ready", if8.s_ready, 0);
    chk("rst_state", dbg8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat packets to every channel, back to back
    for (int k = 0; k < 8; k++) begin
      drive8(1'b1, 3'(k), 8'hA0 + 8'(k), 1'b1);
      #1 chk("single_s_ready", if8.s_ready, 1);
      @(negedge clk);
      chk("single_m_valid", if8.m_valid, 64'(1) << k);
      chk("single_m_data", if8.m_data, 64'(8'hA0 + k) << (8 * k));
      chk("single_m_last", if8.m_last, 64'(1) << k);
      chk("single_busy", busy8, 0);
    end
    drive8(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("single_drained", if8.m_valid, 0);

    // 4-beat packet to ch 3; select moves to 5 after the first beat
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, (i == 0) ? 3'd3 : 3'd5, 8'h30 + 8'(i), (i == 3));
      @(negedge clk);
      chk("pkt4_m_valid", if8.m_valid, 64'h08);
      chk("pkt4_m_data", if8.m_data, 64'(8'h30 + i) << 24);
      chk("pkt4_m_last", if8.m_last, (i == 3) ? 64'h08 : 64'h00);
      chk("pkt4_busy", busy8, (i != 3));
    end
    drive8(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("pkt4_drained", if8.m_valid, 0);

    // Backpressure on ch 2 with a beat also parked on ch 6
    if8.m_ready = 8'hBB;
    drive8(1'b1, 3'd6, 8'h66, 1'b1);
    @(negedge clk);
    chk("bp_ch6_held", if8.m_valid, 64'h40);
    drive8(1'b1, 3'd2, 8'h21, 1'b0);
    exp_q.push_back(8'h21);
    #1 chk("bp_first_ready", if8.s_ready, 1);
    @(negedge clk);
    chk("bp_both_held", if8.m_valid, 64'h44);
    drive8(1'b1, 3'd2, 8'h22, 1'b0);
    exp_q.push_back(8'h22);
    #1 chk("bp_stall_ready", if8.s_ready, 0);
    @(negedge clk);
    chk("bp_stall_valid", if8.m_valid, 64'h44);
    chk("bp_stall_data", if8.m_data[23:16], 8'h21);
    if8.m_ready = 8'hFB;
    @(negedge clk);
    chk("bp_ch6_drained", if8.m_valid, 64'h04);
    chk("bp_still_stalled", if8.s_ready, 0);
    if8.m_ready = 8'hFF;
    #1 chk("bp_release_ready", if8.s_ready, 1);
    e = exp_q.pop_front();
    chk("bp_order", if8.m_data[23:16], e);
    @(negedge clk);
    drive8(1'b1, 3'd2, 8'h23, 1'b1);
    exp_q.push_back(8'h23);
    e = exp_q.pop_front();
    chk("bp_order", if8.m_data[23:16], e);
    chk("bp_mid_last", if8.m_last[2], 0);
    @(negedge clk);
    drive8(1'b0, 3'd0, 8'h00, 1'b0);
    e = exp_q.pop_front();
    chk("bp_order", if8.m_data[23:16], e);
    chk("bp_end_last", if8.m_last[2], 1);
    @(negedge clk);
    chk("bp_empty", if8.m_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // NUM_CH = 5: 3-beat packet with select 6 is dropped
    for (int i = 0; i < 3; i++) begin
      drive5(1'b1, 3'd6, 8'h50 + 8'(i), (i == 2));
      #1 chk("drop_s_ready", if5.s_ready, 1);
      @(negedge clk);
      chk("drop_pulse", drop_pulse5, 1);
      chk("drop_m_valid", if5.m_valid, 0);
      chk("drop_cnt", drop_cnt5, i + 1);
      chk("drop_busy", busy5, (i != 2));
    end
    drive5(1'b1, 3'd4, 8'h44, 1'b1);
    @(negedge clk);
    drive5(1'b0, 3'd0, 8'h00, 1'b0);
    chk("after_drop_valid", if5.m_valid, 5'h10);
    chk("after_drop_data", if5.m_data, 64'h44 << 32);
    chk("after_drop_pulse", drop_pulse5, 0);
    chk("after_drop_cnt", drop_cnt5, 3);

    // 300 dropped beats saturate the counter
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      drive5(1'b1, 3'd7, 8'(i), (i == 299));
      @(negedge clk);
      if (drop_pulse5) pulses++;
    end
    drive5(1'b0, 3'd0, 8'h00, 1'b0);
    chk("sat_pulses", pulses, 300);
    chk("sat_drop_cnt", drop_cnt5, 8'hFF);
    chk("sat_busy", busy5, 0);

    // Reset mid-ROUTE with ch 1 full
    drive8(1'b1, 3'd1, 8'h11, 1'b0);
    @(negedge clk);
    drive8(1'b0, 3'd1, 8'h00, 1'b0);
    chk("mid_ch1_full", if8.m_valid, 64'h02);
    chk("mid_busy", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", if8.m_valid, 0);
    chk("mid_rst_data", if8.m_data, 0);
    chk("mid_rst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive8(1'b1, 3'd2, 8'h2A, 1'b1);
    @(negedge clk);
    drive8(1'b0, 3'd0, 8'h00, 1'b0);
    chk("post_rst_valid", if8.m_valid, 64'h04);
    chk("post_rst_data", if8.m_data, 64'h2A << 16);
    chk("post_rst_busy", busy8, 0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
